// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared FP32 types, constants and helpers for the RV32F arithmetic unit
package fpnew_pkg;

    localparam int          FP32_WIDTH = 32;
    localparam int          FP32_BIAS  = 127;
    localparam logic [31:0] FP32_QNAN  = 32'h7FC0_0000;
    localparam logic [30:0] FP32_INF   = 31'h7F80_0000;
    localparam logic [30:0] FP32_MAXF  = 31'h7F7F_FFFF;

    typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

    typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } fp_class_t;

    // Subnormals have a zero exponent field and are classified as zero (DAZ).
    function automatic fp_class_t fp_class(input logic [31:0] v);
        fp_class_t c;
        c.zero = v[30:23] == 8'd0;
        c.inf  = (&v[30:23]) & ~(|v[22:0]);
        c.nan  = (&v[30:23]) & (|v[22:0]);
        c.snan = c.nan & ~v[22];
        return c;
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] x);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 27; i++)
            if (x[i]) n = 5'(26 - i);
        return n;
    endfunction

endpackage

// File: rtl/fpnew_top_rv32f_if.sv
// fpnew_top_rv32f_if: request/response bundle between the FP pipe and the RV32F unit
interface fpnew_top_rv32f_if import fpnew_pkg::*; #(
    parameter int  WIDTH        = FP32_WIDTH,
    parameter int  NUM_OPERANDS = 3,
    parameter type TagType      = logic
) ();

    logic [NUM_OPERANDS-1:0][WIDTH-1:0] operands_i;
    roundmode_e                         rnd_mode_i;
    operation_e                         op_i;
    logic                               op_mod_i;
    fp_format_e                         src_fmt_i;
    fp_format_e                         dst_fmt_i;
    int_format_e                        int_fmt_i;
    logic                               vectorial_op_i;
    TagType                             tag_i;
    logic                               in_valid_i;
    logic                               in_ready_o;
    logic                               flush_i;
    logic [WIDTH-1:0]                   result_o;
    status_t                            status_o;
    TagType                             tag_o;
    logic                               out_valid_o;
    logic                               out_ready_i;
    logic                               busy_o;

    modport master (
        output operands_i, rnd_mode_i, op_i, op_mod_i, src_fmt_i, dst_fmt_i, int_fmt_i,
               vectorial_op_i, tag_i, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o
    );

    modport slave (
        input  operands_i, rnd_mode_i, op_i, op_mod_i, src_fmt_i, dst_fmt_i, int_fmt_i,
               vectorial_op_i, tag_i, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o
    );

endinterface

// File: rtl/fp32_round.sv
// fp32_round: rounds a normalized significand with guard/round/sticky bits into a binary32 value
module fp32_round import fpnew_pkg::*; (
    input  logic              sign,
    input  logic signed [9:0] exp,
    input  logic [26:0]       man,
    input  roundmode_e        rnd_mode,
    output logic [31:0]       result,
    output logic              of,
    output logic              uf,
    output logic              nx
);

    logic              rs;
    logic              up;
    logic              max_fin;
    logic [24:0]       sum;
    logic signed [9:0] exp_r;
    logic [22:0]       mant;

    // man[26] is the hidden one, man[2] the guard bit, man[1:0] fold into sticky
    always_comb begin
        rs      = man[1] | man[0];
        up      = (rnd_mode == RNE) ? man[2] & (rs | man[3]) :
                  (rnd_mode == RDN) ? sign & (man[2] | rs) :
                  (rnd_mode == RUP) ? ~sign & (man[2] | rs) :
                  (rnd_mode == RMM) ? man[2] : 1'b0;
        sum     = {1'b0, man[26:3]} + 25'(up);
        exp_r   = exp + $signed({9'd0, sum[24]});
        mant    = sum[24] ? sum[23:1] : sum[22:0];
        of      = exp_r >= 10'sd255;
        uf      = ~of & (exp_r < 10'sd1);
        nx      = man[2] | rs | of | uf;
        max_fin = (rnd_mode == RTZ) | ((rnd_mode == RDN) & ~sign) | ((rnd_mode == RUP) & sign);
        result  = of ? {sign, max_fin ? FP32_MAXF : FP32_INF} :
                  uf ? {sign, 31'd0} : {sign, exp_r[7:0], mant};
    end

endmodule

// File: rtl/fpnew_top_rv32f.sv
// fpnew_top_rv32f: RV32F add/sub and mul unit, one registered output stage; FPU_MUL_EN enables MUL
module fpnew_top_rv32f import fpnew_pkg::*; #(
    parameter int  WIDTH        = FP32_WIDTH,
    parameter int  NUM_OPERANDS = 3,
    parameter type TagType      = logic
) (
    input logic              clk_i,
    input logic              rst_i,
    fpnew_top_rv32f_if.slave bus
);

    logic [NUM_OPERANDS-1:0][WIDTH-1:0] ops;
    logic [31:0]       a, b, big, sml;
    fp_class_t         ca, cb;
    logic [7:0]        d;
    logic [50:0]       wide;
    logic [26:0]       big_al, sml_al, add_man;
    logic [27:0]       s;
    logic [4:0]        lz;
    logic signed [9:0] add_exp;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [26:0]       r_man;
    logic [31:0]       rnd_res, res;
    logic              rnd_of, rnd_uf, rnd_nx;
    logic              is_mul, op_ok, legal, in_ready, fire;
    status_t           st;
    logic              valid_q;
    logic [WIDTH-1:0]  result_q;
    status_t           status_q;
    TagType            tag_q;

    assign ops = bus.operands_i;
    assign a   = ops[1];
    assign b   = {ops[2][31] ^ bus.op_mod_i, ops[2][30:0]};
    assign ca  = fp_class(a);
    assign cb  = fp_class(b);

    // Adder: align the smaller magnitude with sticky collection, add/subtract, renormalize
    always_comb begin
        big     = (b[30:0] > a[30:0]) ? b : a;
        sml     = (b[30:0] > a[30:0]) ? a : b;
        d       = big[30:23] - sml[30:23];
        wide    = {1'b1, sml[22:0], 27'd0} >> d;
        sml_al  = {wide[50:25], (|wide[24:0]) | (d > 8'd50)};
        big_al  = {1'b1, big[22:0], 3'd0};
        s       = (big[31] ^ sml[31]) ? {1'b0, big_al} - {1'b0, sml_al} : {1'b0, big_al} + {1'b0, sml_al};
        lz      = lzc27(s[26:0]);
        add_man = s[27] ? {s[27:2], |s[1:0]} : s[26:0] << lz;
        add_exp = s[27] ? $signed({2'd0, big[30:23]}) + 10'sd1 : $signed({2'd0, big[30:23]}) - $signed({5'd0, lz});
    end

`ifdef FPU_MUL_EN
    logic [31:0]       x, y;
    fp_class_t         cx, cy;
    logic [47:0]       p;
    logic [26:0]       mul_man;
    logic signed [9:0] mul_exp;
    logic              mul_sign;

    assign x  = ops[0];
    assign y  = ops[1];
    assign cx = fp_class(x);
    assign cy = fp_class(y);

    // Multiplier: exact 24x24 product, one-bit renormalize, rebias the exponent sum
    always_comb begin
        mul_sign = x[31] ^ y[31];
        p        = {1'b1, x[22:0]} * {1'b1, y[22:0]};
        mul_man  = p[47] ? {p[47:22], |p[21:0]} : {p[46:21], |p[20:0]};
        mul_exp  = $signed({2'd0, x[30:23]}) + $signed({2'd0, y[30:23]}) - 10'sd127 + $signed({9'd0, p[47]});
    end

    assign is_mul = bus.op_i == MUL;
    assign op_ok  = (bus.op_i == ADD) | is_mul;
    assign r_sign = is_mul ? mul_sign : big[31];
    assign r_exp  = is_mul ? mul_exp : add_exp;
    assign r_man  = is_mul ? mul_man : add_man;
`else
    logic unused_mul;

    assign unused_mul = ^ops[0];
    assign is_mul     = 1'b0;
    assign op_ok      = bus.op_i == ADD;
    assign r_sign     = big[31];
    assign r_exp      = add_exp;
    assign r_man      = add_man;
`endif

    logic unused_cfg;
    assign unused_cfg = ^{bus.int_fmt_i, bus.vectorial_op_i};

    fp32_round u_round (
        .sign     (r_sign),
        .exp      (r_exp),
        .man      (r_man),
        .rnd_mode (bus.rnd_mode_i),
        .result   (rnd_res),
        .of       (rnd_of),
        .uf       (rnd_uf),
        .nx       (rnd_nx)
    );

    assign legal = op_ok & (bus.src_fmt_i == FP32) & (bus.dst_fmt_i == FP32);

    // Special-operand overrides on top of the rounded datapath result
    always_comb begin
        res = rnd_res;
        st  = '{nv: 1'b0, dz: 1'b0, of: rnd_of, uf: rnd_uf, nx: rnd_nx};
        if (!legal) begin
            res = FP32_QNAN;
            st  = '{nv: 1'b1, default: 1'b0};
        end
`ifdef FPU_MUL_EN
        else if (is_mul) begin
            if (cx.nan | cy.nan) begin
                res = FP32_QNAN;
                st  = '{nv: cx.snan | cy.snan, default: 1'b0};
            end else if ((cx.inf & cy.zero) | (cx.zero & cy.inf)) begin
                res = FP32_QNAN;
                st  = '{nv: 1'b1, default: 1'b0};
            end else if (cx.inf | cy.inf) begin
                res = {mul_sign, FP32_INF};
                st  = '0;
            end else if (cx.zero | cy.zero) begin
                res = {mul_sign, 31'd0};
                st  = '0;
            end
        end
`endif
        else if (ca.nan | cb.nan) begin
            res = FP32_QNAN;
            st  = '{nv: ca.snan | cb.snan, default: 1'b0};
        end else if (ca.inf & cb.inf & (a[31] ^ b[31])) begin
            res = FP32_QNAN;
            st  = '{nv: 1'b1, default: 1'b0};
        end else if (ca.inf | cb.inf) begin
            res = ca.inf ? a : b;
            st  = '0;
        end else if (ca.zero & cb.zero) begin
            res = {(a[31] == b[31]) ? a[31] : (bus.rnd_mode_i == RDN), 31'd0};
            st  = '0;
        end else if (ca.zero | cb.zero) begin
            res = ca.zero ? b : a;
            st  = '0;
        end else if (s == 28'd0) begin
            res = {bus.rnd_mode_i == RDN, 31'd0};
            st  = '0;
        end
    end

    assign in_ready        = bus.out_ready_i | ~valid_q;
    assign fire            = bus.in_valid_i & in_ready & ~bus.flush_i;
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = valid_q;
    assign bus.busy_o      = valid_q;
    assign bus.result_o    = result_q;
    assign bus.status_o    = status_q;
    assign bus.tag_o       = tag_q;

    // Output stage: load on accepted op, hold under backpressure, flush drops in-flight and same-cycle ops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            tag_q    <= '0;
        end else begin
            if (in_ready | bus.flush_i) valid_q <= fire;
            if (fire) begin
                result_q <= res;
                status_q <= st;
                tag_q    <= bus.tag_i;
            end
        end
    end

endmodule

// File: tb/tb_fpnew_top_rv32f.sv
// tb_fpnew_top_rv32f: directed self-checking bench for the RV32F add/mul unit
module tb_fpnew_top_rv32f;
    import fpnew_pkg::*;

    typedef logic [3:0] tag_t;

    typedef struct {
        string       name;
        operation_e  op;
        roundmode_e  rm;
        fp_format_e  fmt;
        logic        mod;
        logic [31:0] o0, o1, o2, res;
        logic [4:0]  st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    fpnew_top_rv32f_if #(.TagType(tag_t)) bus ();

    fpnew_top_rv32f #(.TagType(tag_t)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input operation_e op, input roundmode_e rm, input logic mod,
                          input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2, input tag_t tag);
        bus.op_i       = op;
        bus.rnd_mode_i = rm;
        bus.op_mod_i   = mod;
        bus.operands_i = {o2, o1, o0};
        bus.tag_i      = tag;
        bus.in_valid_i = 1'b1;
    endtask

    task automatic add_vec(input string name, input operation_e op, input roundmode_e rm, input fp_format_e fmt,
                           input logic mod, input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [31:0] res, input logic [4:0] st);
        vec_t v;
        v.name = name; v.op = op; v.rm = rm; v.fmt = fmt; v.mod = mod;
        v.o0 = o0; v.o1 = o1; v.o2 = o2; v.res = res; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic test_reset();
        bus.operands_i     = '0;
        bus.rnd_mode_i     = RNE;
        bus.op_i           = ADD;
        bus.op_mod_i       = 1'b0;
        bus.src_fmt_i      = FP32;
        bus.dst_fmt_i      = FP32;
        bus.int_fmt_i      = INT32;
        bus.vectorial_op_i = 1'b0;
        bus.tag_i          = '0;
        bus.in_valid_i     = 1'b0;
        bus.out_ready_i    = 1'b1;
        bus.flush_i        = 1'b1;
        rst                = 1'b1;
        repeat (10) step();
        n_cmp++;
        if ({bus.out_valid_o, bus.busy_o, bus.in_ready_o, bus.result_o, bus.status_o, bus.tag_o} !== {3'b001, 32'h0, 5'b0, 4'h0}) begin
            n_bad++;
            $display("FAIL reset: got valid=%b busy=%b ready=%b res=%h st=%b tag=%h, want 0 0 1 00000000 00000 0",
                     bus.out_valid_o, bus.busy_o, bus.in_ready_o, bus.result_o, bus.status_o, bus.tag_o);
        end
        rst         = 1'b0;
        bus.flush_i = 1'b0;
        step();
        n_cmp++;
        if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL idle_after_reset: got valid=%b ready=%b, want 0 1", bus.out_valid_o, bus.in_ready_o);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] snan = 32'h7F80_0001;
        add_vec("sub_rne",      ADD, RNE, FP32, 1'b1, snan, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'b00000);
        add_vec("sub_rdn",      ADD, RDN, FP32, 1'b1, snan, 32'h3F800000, 32'h3F800000, 32'h80000000, 5'b00000);
        add_vec("add_one_one",  ADD, RNE, FP32, 1'b0, snan, 32'h3F800000, 32'h3F800000, 32'h40000000, 5'b00000);
        add_vec("one_minus_3q", ADD, RNE, FP32, 1'b1, snan, 32'h3F800000, 32'h3F400000, 32'h3E800000, 5'b00000);
        add_vec("ovf_rne",      ADD, RNE, FP32, 1'b0, snan, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5'b00101);
        add_vec("ovf_rtz",      ADD, RTZ, FP32, 1'b0, snan, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'b00101);
        add_vec("ovf_rdn_pos",  ADD, RDN, FP32, 1'b0, snan, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'b00101);
        add_vec("ovf_rup_neg",  ADD, RUP, FP32, 1'b0, snan, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF, 5'b00101);
        add_vec("ovf_rup_pos",  ADD, RUP, FP32, 1'b0, snan, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5'b00101);
        add_vec("tie_rne",      ADD, RNE, FP32, 1'b0, snan, 32'h3F800000, 32'h33800000, 32'h3F800000, 5'b00001);
        add_vec("tie_rmm",      ADD, RMM, FP32, 1'b0, snan, 32'h3F800000, 32'h33800000, 32'h3F800001, 5'b00001);
        add_vec("tie_rup",      ADD, RUP, FP32, 1'b0, snan, 32'h3F800000, 32'h33800000, 32'h3F800001, 5'b00001);
        add_vec("tie_rtz",      ADD, RTZ, FP32, 1'b0, snan, 32'h3F800000, 32'h33800000, 32'h3F800000, 5'b00001);
        add_vec("tiny_flush",   ADD, RNE, FP32, 1'b1, snan, 32'h00C00000, 32'h00800000, 32'h00000000, 5'b00011);
        add_vec("daz_input",    ADD, RNE, FP32, 1'b0, snan, 32'h3F800000, 32'h00000001, 32'h3F800000, 5'b00000);
        add_vec("snan_in",      ADD, RNE, FP32, 1'b0, 32'h0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000);
        add_vec("qnan_in",      ADD, RNE, FP32, 1'b0, 32'h0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000);
        add_vec("inf_m_inf",    ADD, RNE, FP32, 1'b1, snan, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000);
        add_vec("neg_inf_p1",   ADD, RNE, FP32, 1'b0, snan, 32'hFF800000, 32'h3F800000, 32'hFF800000, 5'b00000);
        add_vec("div_illegal",  DIV, RNE, FP32, 1'b0, 32'h0, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 5'b10000);
        add_vec("fmt_fp64",     ADD, RNE, FP64, 1'b0, 32'h0, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 5'b10000);
`ifdef FPU_MUL_EN
        add_vec("mul_inf_zero", MUL, RNE, FP32, 1'b0, 32'h7F800000, 32'h00000000, snan, 32'h7FC00000, 5'b10000);
        add_vec("mul_2x3",      MUL, RNE, FP32, 1'b0, 32'h40000000, 32'h40400000, snan, 32'h40C00000, 5'b00000);
        add_vec("mul_m2x3",     MUL, RNE, FP32, 1'b0, 32'hC0000000, 32'h40400000, snan, 32'hC0C00000, 5'b00000);
`else
        add_vec("mul_disabled", MUL, RNE, FP32, 1'b0, 32'h40000000, 32'h40400000, 32'h0, 32'h7FC00000, 5'b10000);
`endif
        foreach (vecs[i]) begin
            set_op(vecs[i].op, vecs[i].rm, vecs[i].mod, vecs[i].o0, vecs[i].o1, vecs[i].o2, tag_t'(i));
            bus.src_fmt_i = vecs[i].fmt;
            step();
            n_cmp++;
            if ({bus.out_valid_o, bus.result_o, bus.status_o, bus.tag_o} !== {1'b1, vecs[i].res, vecs[i].st, tag_t'(i)}) begin
                n_bad++;
                $display("FAIL %s: got valid=%b res=%h st=%b tag=%h, want valid=1 res=%h st=%b tag=%h", vecs[i].name,
                         bus.out_valid_o, bus.result_o, bus.status_o, bus.tag_o, vecs[i].res, vecs[i].st, tag_t'(i));
            end
        end
        bus.in_valid_i = 1'b0;
        bus.src_fmt_i  = FP32;
        step();
        n_cmp++;
        if (bus.out_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL drain: got valid=%b, want 0", bus.out_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        set_op(ADD, RNE, 1'b0, 32'h0, 32'h3F800000, 32'h3F800000, 4'h5);
        step();
        set_op(ADD, RNE, 1'b0, 32'h0, 32'h3F800000, 32'h40000000, 4'h6);
        n_cmp++;
        if ({bus.out_valid_o, bus.result_o, bus.tag_o} !== {1'b1, 32'h40000000, 4'h5}) begin
            n_bad++;
            $display("FAIL b2b_first: got valid=%b res=%h tag=%h, want 1 40000000 5", bus.out_valid_o, bus.result_o, bus.tag_o);
        end
        step();
        bus.in_valid_i = 1'b0;
        n_cmp++;
        if ({bus.out_valid_o, bus.result_o, bus.tag_o} !== {1'b1, 32'h40400000, 4'h6}) begin
            n_bad++;
            $display("FAIL b2b_second: got valid=%b res=%h tag=%h, want 1 40400000 6", bus.out_valid_o, bus.result_o, bus.tag_o);
        end
        step();
        n_cmp++;
        if ({bus.out_valid_o, bus.busy_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_idle: got valid=%b busy=%b, want 0 0", bus.out_valid_o, bus.busy_o);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready_i = 1'b0;
        set_op(ADD, RNE, 1'b0, 32'h0, 32'h3F800000, 32'h3F800000, 4'h1);
        step();
        set_op(ADD, RNE, 1'b0, 32'h0, 32'h3F800000, 32'h40000000, 4'h2);
        n_cmp++;
        if ({bus.out_valid_o, bus.in_ready_o, bus.busy_o, bus.result_o} !== {3'b101, 32'h40000000}) begin
            n_bad++;
            $display("FAIL bp_stall: got valid=%b ready=%b busy=%b res=%h, want 1 0 1 40000000",
                     bus.out_valid_o, bus.in_ready_o, bus.busy_o, bus.result_o);
        end
        step();
        n_cmp++;
        if ({bus.out_valid_o, bus.result_o, bus.status_o, bus.tag_o} !== {1'b1, 32'h40000000, 5'b0, 4'h1}) begin
            n_bad++;
            $display("FAIL bp_hold: got valid=%b res=%h st=%b tag=%h, want 1 40000000 00000 1",
                     bus.out_valid_o, bus.result_o, bus.status_o, bus.tag_o);
        end
        bus.out_ready_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        n_cmp++;
        if ({bus.out_valid_o, bus.result_o, bus.tag_o} !== {1'b1, 32'h40400000, 4'h2}) begin
            n_bad++;
            $display("FAIL bp_release: got valid=%b res=%h tag=%h, want 1 40400000 2", bus.out_valid_o, bus.result_o, bus.tag_o);
        end
        step();
        n_cmp++;
        if (bus.out_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got valid=%b, want 0", bus.out_valid_o);
        end
    endtask

    task automatic test_flush();
        set_op(ADD, RNE, 1'b0, 32'h0, 32'h3F800000, 32'h3F800000, 4'h3);
        step();
        set_op(ADD, RNE, 1'b0, 32'h0, 32'h3F800000, 32'h40000000, 4'h4);
        bus.flush_i = 1'b1;
        n_cmp++;
        if ({bus.out_valid_o, bus.in_ready_o} !== 2'b11) begin
            n_bad++;
            $display("FAIL flush_pre: got valid=%b ready=%b, want 1 1", bus.out_valid_o, bus.in_ready_o);
        end
        step();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        n_cmp++;
        if ({bus.out_valid_o, bus.busy_o, bus.in_ready_o} !== 3'b001) begin
            n_bad++;
            $display("FAIL flush_kill: got valid=%b busy=%b ready=%b, want 0 0 1", bus.out_valid_o, bus.busy_o, bus.in_ready_o);
        end
        step();
        n_cmp++;
        if (bus.out_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drop: got valid=%b, want 0", bus.out_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
